// File: rtl/mul_pkg.sv
// Shared encodings and constants for the RV32M multiply sequencer.
// The fixed four-pass shift order and the accept-to-done latencies are defined here.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    localparam logic [1:0] SFT_P0 = 2'b00;
    localparam logic [1:0] SFT_P1 = 2'b01;
    localparam logic [1:0] SFT_P2 = 2'b11;
    localparam logic [1:0] SFT_P3 = 2'b10;

    localparam int MUL_LAT_FULL = 9;
    localparam int MUL_LAT_FUSE = 2;

    // One-hot bit positions, so single outputs can tap a state flop directly.
    localparam int S_IDLE   = 0;
    localparam int S_CLR    = 1;
    localparam int S_LOAD   = 2;
    localparam int S_P0     = 3;
    localparam int S_P1     = 4;
    localparam int S_P2     = 5;
    localparam int S_P3     = 6;
    localparam int S_DR0    = 7;
    localparam int S_DR1    = 8;
    localparam int S_DONE   = 9;
    localparam int S_REUSE  = 10;
    localparam int N_STATES = 11;

    typedef enum logic [N_STATES-1:0] {
        IDLE  = N_STATES'(1) << S_IDLE,
        CLR   = N_STATES'(1) << S_CLR,
        LOAD  = N_STATES'(1) << S_LOAD,
        P0    = N_STATES'(1) << S_P0,
        P1    = N_STATES'(1) << S_P1,
        P2    = N_STATES'(1) << S_P2,
        P3    = N_STATES'(1) << S_P3,
        DR0   = N_STATES'(1) << S_DR0,
        DR1   = N_STATES'(1) << S_DR1,
        DONE  = N_STATES'(1) << S_DONE,
        REUSE = N_STATES'(1) << S_REUSE
    } state_e;

    function automatic logic op_upper(input mul_op_e op);
        return op != OP_MUL;
    endfunction

    function automatic logic op_signed_a(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic op_signed_b(input mul_op_e op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/multiplier_ctrl_if.sv
// Request/response handshake between the core (master) and the multiply controller (slave).
interface multiplier_ctrl_if;
    import mul_pkg::*;

    logic        start_i;
    logic        ready_o;
    mul_op_e     op_i;
    logic [31:0] op_A_i;
    logic [31:0] op_B_i;
    logic        done_o;

    modport master (output start_i, op_i, op_A_i, op_B_i, input ready_o, done_o);
    modport slave  (input start_i, op_i, op_A_i, op_B_i, output ready_o, done_o);

endinterface

// File: rtl/mul_fuse_cache.sv
// Operand store for fusion: remembers the last fully computed A/B and signedness,
// and flags a request whose partial products already sit in the datapath.
module mul_fuse_cache
    import mul_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        load_sa,
    input  logic        load_sb,
    input  mul_op_e     req_op,
    output logic        hit
);

    logic [31:0] last_a;
    logic [31:0] last_b;
    logic        last_sa;
    logic        last_sb;
    logic        valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_a  <= '0;
            last_b  <= '0;
            last_sa <= 1'b0;
            last_sb <= 1'b0;
            valid   <= 1'b0;
        end else if (load) begin
            last_a  <= op_a;
            last_b  <= op_b;
            last_sa <= load_sa;
            last_sb <= load_sb;
            valid   <= 1'b1;
        end
    end

    // MUL returns the low word, which is the same whatever signedness built the product.
    assign hit = valid && (op_a == last_a) && (op_b == last_b) &&
                 ((req_op == OP_MUL) ||
                  ({op_signed_a(req_op), op_signed_b(req_op)} == {last_sa, last_sb}));

endmodule

// File: rtl/multiplier_ctrl.sv
// Moore sequencer for the 4-lane byte-sliced multiplier datapath.
// Define MUL_FUSE_EN to enable operand-reuse fusion (2-cycle path on a repeated operand pair).
module multiplier_ctrl
    import mul_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    multiplier_ctrl_if.slave        bus,
    output logic                    dp_rst_o,
    output logic                    upper_o,
    output logic                    reg_A_en_o,
    output logic                    reg_B_en_o,
    output logic                    AC_en_o,
    output logic                    en_pipe_o,
    output logic                    mux_B_sel_o,
    output logic                    rol_en_o,
    output logic                    signed_A_o,
    output logic                    signed_B_o,
    output logic [1:0]              shift_amount_o
);

    state_e  state_q;
    state_e  state_d;
    mul_op_e op_q;
    logic    accept;
    logic    hit;

    assign bus.ready_o = state_q[S_IDLE] | state_q[S_DONE];
    assign accept      = bus.start_i && bus.ready_o;
    assign dp_rst_o    = state_q[S_CLR];

`ifdef MUL_FUSE_EN
    mul_fuse_cache u_fuse_cache (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (state_q[S_LOAD]),
        .op_a    (bus.op_A_i),
        .op_b    (bus.op_B_i),
        .load_sa (op_signed_a(op_q)),
        .load_sb (op_signed_b(op_q)),
        .req_op  (bus.op_i),
        .hit     (hit)
    );
`else
    logic unused_operands;
    assign unused_operands = ^{bus.op_A_i, bus.op_B_i};
    assign hit             = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
        end else begin
            state_q <= state_d;
            if (accept) op_q <= bus.op_i;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d        = state_q;
        bus.done_o     = 1'b0;
        reg_A_en_o     = 1'b0;
        reg_B_en_o     = 1'b0;
        AC_en_o        = 1'b0;
        en_pipe_o      = 1'b0;
        mux_B_sel_o    = 1'b0;
        rol_en_o       = 1'b0;
        shift_amount_o = SFT_P0;
        upper_o        = !state_q[S_IDLE] && op_upper(op_q);
        signed_A_o     = !state_q[S_IDLE] && op_signed_a(op_q);
        signed_B_o     = !state_q[S_IDLE] && op_signed_b(op_q);

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = hit ? REUSE : CLR;
            end
            CLR:  state_d = LOAD;
            LOAD: begin
                reg_A_en_o = 1'b1;
                reg_B_en_o = 1'b1;
                state_d    = P0;
            end
            P0, P1, P2, P3: begin
                reg_B_en_o  = 1'b1;
                mux_B_sel_o = 1'b1;
                rol_en_o    = 1'b1;
                en_pipe_o   = 1'b1;
                // Accumulate lags its pass by one stage to meet the datapath result register.
                AC_en_o     = !state_q[S_P0];
                if (state_q[S_P0]) begin
                    shift_amount_o = SFT_P0;
                    state_d        = P1;
                end else if (state_q[S_P1]) begin
                    shift_amount_o = SFT_P1;
                    state_d        = P2;
                end else if (state_q[S_P2]) begin
                    shift_amount_o = SFT_P2;
                    state_d        = P3;
                end else begin
                    shift_amount_o = SFT_P3;
                    state_d        = DR0;
                end
            end
            DR0: begin
                en_pipe_o = 1'b1;
                AC_en_o   = 1'b1;
                state_d   = DR1;
            end
            DR1: begin
                // Pushes a zero AC-enable into the pipe so the accumulator stops.
                en_pipe_o = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                bus.done_o = 1'b1;
                if (accept) state_d = hit ? REUSE : CLR;
                else        state_d = IDLE;
            end
            REUSE: begin
                reg_A_en_o = 1'b1;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multiplier_ctrl.sv
// Directed bench for multiplier_ctrl: compares the full control vector cycle by cycle
// against hand-written sequences for each RV32M op, back-to-back, abort and fusion cases.
module tb_multiplier_ctrl;
    import mul_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       dp_rst, upper, reg_a_en, reg_b_en, ac_en, en_pipe, mux_b_sel, rol_en;
    logic       signed_a, signed_b;
    logic [1:0] shift_amount;
    logic [13:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    multiplier_ctrl_if bus ();

    multiplier_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .bus            (bus),
        .dp_rst_o       (dp_rst),
        .upper_o        (upper),
        .reg_A_en_o     (reg_a_en),
        .reg_B_en_o     (reg_b_en),
        .AC_en_o        (ac_en),
        .en_pipe_o      (en_pipe),
        .mux_B_sel_o    (mux_b_sel),
        .rol_en_o       (rol_en),
        .signed_A_o     (signed_a),
        .signed_B_o     (signed_b),
        .shift_amount_o (shift_amount)
    );

    always #5 clk = ~clk;

    // {ready, done, dp_rst, reg_A_en, reg_B_en, AC_en, en_pipe, mux_B_sel, rol_en, shift[1:0], upper, sA, sB}
    assign obs = {bus.ready_o, bus.done_o, dp_rst, reg_a_en, reg_b_en, ac_en, en_pipe,
                  mux_b_sel, rol_en, shift_amount, upper, signed_a, signed_b};

    // Expected op-independent bits for cycles c1..c9 of the full path.
    localparam logic [10:0] FULL_SEQ [9] = '{
        11'b0_0_1_0_0_0_0_0_0_00,  // c1 CLR
        11'b0_0_0_1_1_0_0_0_0_00,  // c2 LOAD
        11'b0_0_0_0_1_0_1_1_1_00,  // c3 P0
        11'b0_0_0_0_1_1_1_1_1_01,  // c4 P1
        11'b0_0_0_0_1_1_1_1_1_11,  // c5 P2
        11'b0_0_0_0_1_1_1_1_1_10,  // c6 P3
        11'b0_0_0_0_0_1_1_0_0_00,  // c7 DR0
        11'b0_0_0_0_0_0_1_0_0_00,  // c8 DR1
        11'b1_1_0_0_0_0_0_0_0_00   // c9 DONE
    };
    localparam logic [13:0] IDLE_VEC  = 14'b1_0_0_0_0_0_0_0_0_00_000;
    localparam logic [13:0] REUSE_VEC = 14'b0_0_0_1_0_0_0_0_0_00_000;
    localparam logic [13:0] DONE_MUL  = 14'b1_1_0_0_0_0_0_0_0_00_000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the controller should be ready.
    task automatic accept_req(input string tag, input mul_op_e op, input logic [31:0] a,
                              input logic [31:0] b);
        check({tag, " ready"}, 32'(bus.ready_o), 32'd1);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.op_A_i  = a;
        bus.op_B_i  = b;
        @(posedge clk);
    endtask

    // Checks c1..c9; optionally issues the next request during DONE.
    task automatic watch_full(input string tag, input logic [2:0] eop, input bit chain,
                              input mul_op_e op2, input logic [31:0] a2, input logic [31:0] b2);
        for (int c = 1; c <= MUL_LAT_FULL; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            check($sformatf("%s c%0d", tag, c), 32'(obs), 32'({FULL_SEQ[c-1], eop}));
        end
        if (chain) begin
            bus.start_i = 1'b1;
            bus.op_i    = op2;
            bus.op_A_i  = a2;
            bus.op_B_i  = b2;
            @(posedge clk);
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, " idle"}, 32'(obs), 32'(IDLE_VEC));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = OP_MUL;
        bus.op_A_i  = '0;
        bus.op_B_i  = '0;

        @(negedge clk);
        check("reset held", 32'(obs), 32'(IDLE_VEC));
        @(negedge clk);
        rst_i = 1'b0;
        expect_idle("after reset");

        accept_req("mul 7x6", OP_MUL, 32'd7, 32'd6);
        watch_full("mul 7x6", 3'b000, 1'b0, OP_MUL, '0, '0);
        expect_idle("mul 7x6");

        accept_req("mulh ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch_full("mulh ff", 3'b111, 1'b0, OP_MUL, '0, '0);
        expect_idle("mulh ff");

        accept_req("mulhu ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch_full("mulhu ff", 3'b100, 1'b0, OP_MUL, '0, '0);
        expect_idle("mulhu ff");

        accept_req("mulhsu", OP_MULHSU, 32'h8000_0000, 32'h0000_0002);
        watch_full("mulhsu", 3'b110, 1'b0, OP_MUL, '0, '0);
        expect_idle("mulhsu");

        // Back-to-back: second request accepted in DONE, no bubble.
        accept_req("b2b first", OP_MUL, 32'd7, 32'd6);
        watch_full("b2b first", 3'b000, 1'b1, OP_MUL, 32'd3, 32'd5);
        watch_full("b2b second", 3'b000, 1'b0, OP_MUL, '0, '0);
        expect_idle("b2b second");

        // Abort during P2, then a fresh request.
        accept_req("abort", OP_MULHU, 32'd7, 32'd6);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
        end
        check("abort in P2", 32'(obs), 32'({FULL_SEQ[4], 3'b100}));
        rst_i = 1'b1;
        #1;
        check("abort async", 32'(obs), 32'(IDLE_VEC));
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("abort quiet %0d", c), 32'(obs), 32'(IDLE_VEC));
        end
        accept_req("mul 2x3", OP_MUL, 32'd2, 32'd3);
        watch_full("mul 2x3", 3'b000, 1'b0, OP_MUL, '0, '0);
        expect_idle("mul 2x3");

        // Operand reuse: MULHU then MUL on identical operands.
        accept_req("fuse mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch_full("fuse mulhu", 3'b100, 1'b0, OP_MUL, '0, '0);
        expect_idle("fuse mulhu");
        accept_req("fuse mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MUL_FUSE_EN
        @(negedge clk);
        bus.start_i = 1'b0;
        check("fuse mul c1 reuse", 32'(obs), 32'(REUSE_VEC));
        @(negedge clk);
        check($sformatf("fuse mul c%0d done", MUL_LAT_FUSE), 32'(obs), 32'(DONE_MUL));
`else
        watch_full("fuse mul", 3'b000, 1'b0, OP_MUL, '0, '0);
`endif
        expect_idle("fuse mul");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
